// File: rtl/conv_mac_pkg.sv
// Shared definitions for the convolution MAC controller: state encoding,
// operand widths and output saturation limits.
package conv_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } mac_state_t;

  localparam int W_W = 8;
  localparam int X_W = 16;
  localparam int P_W = 24;
  localparam int Y_W = 16;

  localparam int Y_MAX = 32767;
  localparam int Y_MIN = -32768;

endpackage

// File: rtl/conv_mac_ctrl_mul.sv
// Combinational signed 8x16 multiplier producing a full-precision 24-bit product.
module conv_mac_ctrl_mul
  import conv_mac_pkg::*;
(
  input  logic [W_W-1:0] a,
  input  logic [X_W-1:0] b,
  output logic [P_W-1:0] p
);

  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;

  // Both operands widened to the product width so the multiply is exact.
  assign a_ext = $signed({{(P_W-W_W){a[W_W-1]}}, a});
  assign b_ext = $signed({{(P_W-X_W){b[X_W-1]}}, b});
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/conv_mac_ctrl.sv
// Dot-product controller: consumes KLEN joint weight/activation pairs, adds them
// onto a bias, then presents a shifted, saturated 16-bit result.
module conv_mac_ctrl
  import conv_mac_pkg::*;
#(
  parameter int KLEN  = 9,
  parameter int ACC_W = 32,
  parameter int SHIFT = 0
) (
  input  logic           ap_clk,
  input  logic           ap_rst,
  input  logic           ap_start,
  output logic           ap_ready,
  output logic           ap_idle,
  output logic           ap_done,
  input  logic [15:0]    bias,
  input  logic [7:0]     w_data,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic [15:0]    x_data,
  input  logic           x_valid,
  output logic           x_ready,
  output logic [15:0]    y_data,
  output logic           y_valid,
  input  logic           y_ready
);

  localparam logic [7:0] CNT_LAST = 8'(KLEN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(Y_MAX);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(Y_MIN);

  mac_state_t              state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg;
  logic [7:0]              cnt_reg;
  logic [P_W-1:0]          p_reg;
  logic                    pv_reg;

  logic                    fire;
  logic                    start_acc;
  logic [P_W-1:0]          mul_p;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] acc_sh;
  logic [Y_W-1:0]          y_sat;

  conv_mac_ctrl_mul u_mul (
    .a (w_data),
    .b (x_data),
    .p (mul_p)
  );

  assign start_acc = (state_reg == ST_IDLE) & ap_start & ~ap_rst;
  assign fire      = (state_reg == ST_RUN) & w_valid & x_valid & ~ap_rst;
  assign w_ready   = fire;
  assign x_ready   = fire;

  assign bias_ext = $signed({{(ACC_W-Y_W){bias[Y_W-1]}}, bias});
  assign p_ext    = $signed({{(ACC_W-P_W){p_reg[P_W-1]}}, p_reg});

  // Arithmetic shift floors toward -inf; clamp afterwards to the 16-bit range.
  assign acc_sh = acc_reg >>> SHIFT;
  assign y_sat  = (acc_sh > SAT_MAX) ? Y_W'(Y_MAX) :
                  (acc_sh < SAT_MIN) ? Y_W'(Y_MIN) : acc_sh[Y_W-1:0];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ap_ready   = 1'b0;
    ap_idle    = 1'b0;
    ap_done    = 1'b0;
    y_valid    = 1'b0;
    y_data     = '0;
    if (ap_rst) begin
      ap_idle = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ap_idle = 1'b1;
          if (ap_start) begin
            ap_ready   = 1'b1;
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (fire && (cnt_reg == CNT_LAST)) state_next = ST_DRAIN;
        end
        ST_DRAIN: state_next = ST_OUT;
        ST_OUT: begin
          y_valid = 1'b1;
          y_data  = y_sat;
          if (y_ready) begin
            ap_done    = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // The product is registered one cycle ahead of its accumulation; DRAIN
  // exists so the last registered product lands before OUT.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      p_reg   <= '0;
      pv_reg  <= 1'b0;
    end else begin
      pv_reg <= fire;
      if (fire) begin
        p_reg   <= mul_p;
        cnt_reg <= cnt_reg + 8'd1;
      end
      if (start_acc) begin
        acc_reg <= bias_ext;
        cnt_reg <= '0;
      end else if (pv_reg) begin
        acc_reg <= acc_reg + p_ext;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed self-checking bench for conv_mac_ctrl (SHIFT=0 and SHIFT=8 instances).
module tb_conv_mac_ctrl;

  logic        ap_clk = 1'b0;
  logic        ap_rst, ap_start, w_valid, x_valid, y_ready;
  logic [15:0] bias, x_data;
  logic [7:0]  w_data;

  logic        ap_ready, ap_idle, ap_done, w_ready, x_ready, y_valid;
  logic [15:0] y_data;
  logic        s8_ap_ready, s8_ap_idle, s8_ap_done, s8_w_ready, s8_x_ready, s8_y_valid;
  logic [15:0] s8_y_data;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  conv_mac_ctrl #(.KLEN(9), .ACC_W(32), .SHIFT(0)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .ap_done(ap_done), .bias(bias),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  conv_mac_ctrl #(.KLEN(9), .ACC_W(32), .SHIFT(8)) dut_s8 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(s8_ap_ready),
    .ap_idle(s8_ap_idle), .ap_done(s8_ap_done), .bias(bias),
    .w_data(w_data), .w_valid(w_valid), .w_ready(s8_w_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(s8_x_ready),
    .y_data(s8_y_data), .y_valid(s8_y_valid), .y_ready(y_ready)
  );

  task automatic step;
    @(posedge ap_clk);
    #1;
  endtask

  // Steps through the accept edge and RUN/DRAIN until y_valid rises.
  task automatic run_to_out(input bit toggle, input bit keep_start,
                            output int lat, output int fires,
                            output bit tmo, output bit joint_bad);
    lat = 0; fires = 0; tmo = 1'b0; joint_bad = 1'b0;
    step();
    if (!keep_start) ap_start = 1'b0;
    lat = 1;
    while (!y_valid) begin
      if (toggle) x_valid = ~x_valid;
      #1;
      if (w_ready !== x_ready) joint_bad = 1'b1;
      if (w_ready && w_valid && x_valid) fires++;
      if (lat >= 60) begin
        tmo = 1'b1;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic begin_op(input logic [15:0] b, input logic [7:0] w, input logic [15:0] x);
    bias = b; w_data = w; x_data = x;
    w_valid = 1'b1; x_valid = 1'b1; y_ready = 1'b0;
    ap_start = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    ap_rst = 1'b1; ap_start = 1'b1; w_valid = 1'b1; x_valid = 1'b1; y_ready = 1'b1;
    bias = 16'h1234; w_data = 8'h01; x_data = 16'h0001;
    step(); step();
    checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
    checks++; if (ap_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ap_ready); end
    checks++; if ({ap_done, w_ready, x_ready, y_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_handshakes got=%b exp=0000", {ap_done, w_ready, x_ready, y_valid}); end
    checks++; if (y_data !== 16'h0000) begin errors++; $display("FAIL reset_ydata got=%h exp=0000", y_data); end
    ap_rst = 1'b0; ap_start = 1'b0; y_ready = 1'b0;
    step();
    checks++; if (ap_idle !== 1'b1 || w_ready !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got idle=%b wr=%b exp idle=1 wr=0", ap_idle, w_ready); end
    $display("test_reset: idle=%b ready=%b y_data=%h", ap_idle, ap_ready, y_data);
  endtask

  task automatic test_basic;
    int lat, fires; bit tmo, jb;
    begin_op(16'h0000, 8'h01, 16'h0001);
    checks++; if (ap_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", ap_ready); end
    run_to_out(1'b0, 1'b0, lat, fires, tmo, jb);
    checks++; if (tmo) begin errors++; $display("FAIL basic_timeout got=timeout exp=y_valid"); end
    checks++; if (lat != 11) begin errors++; $display("FAIL basic_latency got=%0d exp=11", lat); end
    checks++; if (fires != 9) begin errors++; $display("FAIL basic_fires got=%0d exp=9", fires); end
    checks++; if (jb) begin errors++; $display("FAIL basic_joint got=split exp=joint"); end
    checks++; if (y_data !== 16'd9) begin errors++; $display("FAIL basic_y got=%0d exp=9", $signed(y_data)); end
    checks++; if (s8_y_data !== 16'd0) begin errors++; $display("FAIL basic_y_s8 got=%0d exp=0", $signed(s8_y_data)); end
    checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL basic_done_early got=%b exp=0", ap_done); end
    y_ready = 1'b1; #1;
    checks++; if (ap_done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", ap_done); end
    step(); y_ready = 1'b0; #1;
    checks++; if (ap_idle !== 1'b1 || ap_done !== 1'b0 || y_valid !== 1'b0) begin
      errors++; $display("FAIL basic_back_idle got idle=%b done=%b yv=%b exp 1/0/0", ap_idle, ap_done, y_valid); end
    $display("test_basic: y_data=%0d latency=%0d fires=%0d", $signed(y_data), lat, fires);
  endtask

  task automatic test_saturation;
    int lat, fires; bit tmo, jb;
    begin_op(16'h0000, 8'h80, 16'h8000);
    run_to_out(1'b0, 1'b0, lat, fires, tmo, jb);
    checks++; if (tmo || s8_y_data !== 16'h7FFF) begin
      errors++; $display("FAIL sat_pos_s8 got=%0d exp=32767", $signed(s8_y_data)); end
    checks++; if (y_data !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%0d exp=32767", $signed(y_data)); end
    $display("test_saturation: w=-128 x=-32768 y_s8=%0d", $signed(s8_y_data));
    y_ready = 1'b1; step(); y_ready = 1'b0;
    begin_op(16'h0000, 8'h80, 16'h7FFF);
    run_to_out(1'b0, 1'b0, lat, fires, tmo, jb);
    checks++; if (tmo || s8_y_data !== 16'h8000) begin
      errors++; $display("FAIL sat_neg_s8 got=%0d exp=-32768", $signed(s8_y_data)); end
    checks++; if (y_data !== 16'h8000) begin errors++; $display("FAIL sat_neg got=%0d exp=-32768", $signed(y_data)); end
    $display("test_saturation: w=-128 x=32767 y_s8=%0d", $signed(s8_y_data));
    y_ready = 1'b1; step(); y_ready = 1'b0;
  endtask

  task automatic test_shift_floor;
    int lat, fires; bit tmo, jb;
    begin_op(16'hFFFB, 8'h00, 16'h0000);
    run_to_out(1'b0, 1'b0, lat, fires, tmo, jb);
    checks++; if (tmo || y_data !== 16'hFFFB) begin errors++; $display("FAIL floor_y got=%0d exp=-5", $signed(y_data)); end
    checks++; if (s8_y_data !== 16'hFFFF) begin errors++; $display("FAIL floor_y_s8 got=%0d exp=-1", $signed(s8_y_data)); end
    $display("test_shift_floor: bias=-5 y=%0d y_s8=%0d", $signed(y_data), $signed(s8_y_data));
    y_ready = 1'b1; step(); y_ready = 1'b0;
  endtask

  task automatic test_bubbles;
    int lat, fires; bit tmo, jb;
    begin_op(16'hFFFB, 8'h02, 16'h0003);
    run_to_out(1'b1, 1'b0, lat, fires, tmo, jb);
    checks++; if (tmo) begin errors++; $display("FAIL bubble_timeout got=timeout exp=y_valid"); end
    checks++; if (fires != 9) begin errors++; $display("FAIL bubble_fires got=%0d exp=9", fires); end
    checks++; if (jb) begin errors++; $display("FAIL bubble_joint got=split exp=joint"); end
    checks++; if (y_data !== 16'd49) begin errors++; $display("FAIL bubble_y got=%0d exp=49", $signed(y_data)); end
    checks++; if (lat <= 11) begin errors++; $display("FAIL bubble_stall got_latency=%0d exp>11", lat); end
    $display("test_bubbles: y_data=%0d fires=%0d latency=%0d", $signed(y_data), fires, lat);
    x_valid = 1'b1; y_ready = 1'b1; step(); y_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat, fires; bit tmo, jb;
    bit bad_stable = 1'b0, bad_done = 1'b0, bad_ready = 1'b0;
    begin_op(16'h0000, 8'h01, 16'h0001);
    run_to_out(1'b0, 1'b1, lat, fires, tmo, jb);
    for (int i = 0; i < 5; i++) begin
      if (y_valid !== 1'b1 || y_data !== 16'd9) bad_stable = 1'b1;
      if (ap_done !== 1'b0) bad_done = 1'b1;
      if (ap_ready !== 1'b0) bad_ready = 1'b1;
      step();
    end
    checks++; if (tmo || bad_stable) begin errors++; $display("FAIL bp_stable got=%0d exp=9 held", $signed(y_data)); end
    checks++; if (bad_done) begin errors++; $display("FAIL bp_done got=pulse exp=0"); end
    checks++; if (bad_ready) begin errors++; $display("FAIL bp_ready got=pulse exp=0"); end
    y_ready = 1'b1; #1;
    checks++; if (ap_done !== 1'b1 || ap_ready !== 1'b0) begin
      errors++; $display("FAIL bp_handshake got done=%b ready=%b exp 1/0", ap_done, ap_ready); end
    step();
    checks++; if (ap_idle !== 1'b1 || ap_ready !== 1'b1) begin
      errors++; $display("FAIL bp_idle_ready got idle=%b ready=%b exp 1/1", ap_idle, ap_ready); end
    ap_start = 1'b0; y_ready = 1'b0; #1;
    $display("test_backpressure: y_data=%0d held 5 cycles", $signed(y_data));
    step();
  endtask

  task automatic test_reset_midrun;
    int lat, fires; bit tmo, jb;
    begin_op(16'h0000, 8'h01, 16'h0001);
    step(); ap_start = 1'b0;
    repeat (4) step();
    ap_rst = 1'b1; step();
    checks++; if (ap_idle !== 1'b1 || {ap_ready, ap_done, w_ready, x_ready, y_valid} !== 5'b0 || y_data !== 16'h0) begin
      errors++; $display("FAIL midrun_reset got idle=%b rdy=%b done=%b wr=%b xr=%b yv=%b y=%h exp reset values",
                         ap_idle, ap_ready, ap_done, w_ready, x_ready, y_valid, y_data); end
    ap_rst = 1'b0; #1;
    checks++; if (ap_idle !== 1'b1 || w_ready !== 1'b0) begin
      errors++; $display("FAIL midrun_after got idle=%b wr=%b exp 1/0", ap_idle, w_ready); end
    step();
    begin_op(16'h0000, 8'h01, 16'h0001);
    run_to_out(1'b0, 1'b0, lat, fires, tmo, jb);
    checks++; if (tmo || y_data !== 16'd9 || lat != 11) begin
      errors++; $display("FAIL midrun_next got y=%0d lat=%0d exp y=9 lat=11", $signed(y_data), lat); end
    $display("test_reset_midrun: next y_data=%0d latency=%0d", $signed(y_data), lat);
    y_ready = 1'b1; step(); y_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_shift_floor();
    test_bubbles();
    test_backpressure();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
